// File: rtl/scoreboard_pkg.sv
// Purpose: shared types and helpers for the match scoreboard and its display users.
// Latency: combinational helpers only.
// Backpressure: none.
package scoreboard_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  // Widest thermometer field / pulse vector the helpers handle.
  localparam int unsigned THERM_MAX = 64;

  // Thermometer code: bit k set iff k < min(score, f); LSB lights first.
  function automatic logic [THERM_MAX-1:0] therm(input logic [31:0] score,
                                                  input int unsigned f);
    logic [THERM_MAX-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < THERM_MAX; k++) begin
      t[k] = (k < f) && (k < score);
    end
    return t;
  endfunction

  // True when exactly one bit of vec is set.
  function automatic logic onehot_valid(input logic [THERM_MAX-1:0] vec);
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < THERM_MAX; k++) begin
      if (vec[k]) n++;
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/match_scoreboard_blink_timer.sv
// Purpose: free-running half-period divider producing a blink phase while enabled.
// Latency: phase toggles BLINK_DIV cycles after enable rises, then every BLINK_DIV cycles.
// Backpressure: none; dropping enable clears counter and phase to 0 on the next edge.
module blink_timer #(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic phase
);

  localparam int unsigned DW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [DW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Count 0..BLINK_DIV-1 while enabled, flip phase on wrap; idle state is counter 0, phase dark.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!enable) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == DW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/match_scoreboard.sv
// Purpose: N-player round-win counter with match decision, thermometer LEDs and winner blink.
// Latency: scores/game_over/winner_id one cycle after the pulse; LED one cycle behind scores.
// Backpressure: none; simultaneous pulses are a tie and are dropped, pulses in OVER are ignored.
module match_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned WINS_TO_MATCH = 8,
  parameter int unsigned LED_W         = 16,
  parameter int unsigned BLINK_DIV     = 25_000_000
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic [NUM_PLAYERS-1:0]                               win_pulse,
  input  logic                                                 new_match,
  output logic [NUM_PLAYERS*$clog2(WINS_TO_MATCH+1)-1:0]       score,
  output logic [((NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1)-1:0] winner_id,
  output logic                                                 game_over,
  output logic [LED_W-1:0]                                     LED
);

  localparam int unsigned F  = LED_W / NUM_PLAYERS;
  localparam int unsigned CW = $clog2(WINS_TO_MATCH + 1);
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;

  if (LED_W % NUM_PLAYERS != 0) begin : g_chk_led
    $error("LED_W must be divisible by NUM_PLAYERS");
  end
  if (NUM_PLAYERS < 2 || NUM_PLAYERS > THERM_MAX) begin : g_chk_np
    $error("NUM_PLAYERS out of range");
  end
  if (WINS_TO_MATCH < 1) begin : g_chk_wins
    $error("WINS_TO_MATCH must be at least 1");
  end
  if (BLINK_DIV < 2) begin : g_chk_blink
    $error("BLINK_DIV must be at least 2");
  end
  if (F > THERM_MAX) begin : g_chk_field
    $error("LED field too wide");
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        score_q [NUM_PLAYERS];
  logic [CW-1:0]        score_d [NUM_PLAYERS];
  logic [PW-1:0]        winner_q, winner_d;
  logic [LED_W-1:0]     led_q, led_d;
  logic [THERM_MAX-1:0] wp_ext;
  logic                 blink_en;
  logic                 blink_phase;

  // Scoring FSM: clear wins over everything, a lone pulse scores in PLAY, reaching the target ends the match.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    score_d  = score_q;
    wp_ext   = '0;
    wp_ext[NUM_PLAYERS-1:0] = win_pulse;
    if (new_match) begin
      state_d  = PLAY;
      winner_d = '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) score_d[p] = '0;
    end else if (state_q == PLAY && onehot_valid(wp_ext)) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        if (win_pulse[p]) begin
          score_d[p] = score_q[p] + 1'b1;
          if (score_q[p] == CW'(WINS_TO_MATCH - 1)) begin
            state_d  = OVER;
            winner_d = PW'(p);
          end
        end
      end
    end
  end

  // LED mux from the current scores; the winner's field follows the blink phase once the match is over.
  always_comb begin
    led_d = '0;
    if (!new_match) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        if (state_q == OVER && winner_q == PW'(p)) begin
          led_d[p*F +: F] = {F{blink_phase}};
        end else begin
          led_d[p*F +: F] = F'(therm(32'(score_q[p]), F));
        end
      end
    end
  end

  // State, score, winner and LED registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= PLAY;
      winner_q <= '0;
      led_q    <= '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      led_q    <= led_d;
      score_q  <= score_d;
    end
  end

  // Blink runs only while the match is over; a new match request clears it on the same edge.
  assign blink_en = (state_q == OVER) && !new_match;

  blink_timer #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clock  (clock),
    .reset  (reset),
    .enable (blink_en),
    .phase  (blink_phase)
  );

  // Pack per-player scores onto the output bus.
  always_comb begin
    score = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) score[p*CW +: CW] = score_q[p];
  end

  assign winner_id = winner_q;
  assign game_over = (state_q == OVER);
  assign LED       = led_q;

endmodule

// File: tb/tb_match_scoreboard.sv
module tb_match_scoreboard;

  localparam int BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults (2 players, 8 wins, 16 LEDs).  Instance 1: 4 players, 6 wins.
  logic        r0, nm0, r1, nm1;
  logic [1:0]  wp0;
  logic [3:0]  wp1;
  logic [7:0]  sc0;
  logic [11:0] sc1;
  logic        wid0;
  logic [1:0]  wid1;
  logic        go0, go1;
  logic [15:0] led0, led1;

  match_scoreboard #(.NUM_PLAYERS(2), .WINS_TO_MATCH(8), .LED_W(16), .BLINK_DIV(BD)) dut0 (
    .clock(clk), .reset(r0), .win_pulse(wp0), .new_match(nm0),
    .score(sc0), .winner_id(wid0), .game_over(go0), .LED(led0));

  match_scoreboard #(.NUM_PLAYERS(4), .WINS_TO_MATCH(6), .LED_W(16), .BLINK_DIV(BD)) dut1 (
    .clock(clk), .reset(r1), .win_pulse(wp1), .new_match(nm1),
    .score(sc1), .winner_id(wid1), .game_over(go1), .LED(led1));

  int vec = 0;
  int err = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-instance scores, match-over flag, winner, edges spent in OVER, LED image.
  int          ms [2][4];
  bit          mo [2];
  int          mw [2];
  int          mn [2];
  logic [15:0] ml [2];

  task automatic model_step(input int k, input bit rst, input logic [3:0] wp, input bit nm,
                            input int np, input int wtm, input int f);
    logic [63:0] nl, fld;
    int lit, idx;
    if (rst) begin
      for (int p = 0; p < 4; p++) ms[k][p] = 0;
      mo[k] = 0; mw[k] = 0; mn[k] = 0; ml[k] = '0;
      return;
    end
    // LED image reflects the state before this edge.
    nl = '0;
    if (!nm) begin
      for (int p = 0; p < np; p++) begin
        if (mo[k] && mw[k] == p)
          fld = (((mn[k] / BD) % 2) == 1) ? ((64'd1 << f) - 1) : 64'd0;
        else begin
          lit = (ms[k][p] < f) ? ms[k][p] : f;
          fld = (64'd1 << lit) - 1;
        end
        nl = nl | (fld << (p * f));
      end
    end
    if (nm) begin
      for (int p = 0; p < 4; p++) ms[k][p] = 0;
      mo[k] = 0; mw[k] = 0; mn[k] = 0;
    end else if (mo[k]) begin
      mn[k]++;
    end else if ($countones(wp) == 1) begin
      idx = 0;
      for (int p = 0; p < np; p++) if (wp[p]) idx = p;
      ms[k][idx]++;
      if (ms[k][idx] == wtm) begin
        mo[k] = 1; mw[k] = idx; mn[k] = 0;
      end
    end
    ml[k] = nl[15:0];
  endtask

  always @(posedge clk) begin
    model_step(0, r0, {2'b00, wp0}, nm0, 2, 8, 8);
    model_step(1, r1, wp1, nm1, 4, 6, 4);
  end

  function automatic logic [63:0] pack_scores(input int k, input int np, input int cw);
    logic [63:0] e;
    e = '0;
    for (int p = 0; p < np; p++) e = e | (64'(ms[k][p]) << (p * cw));
    return e;
  endfunction

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("i0_score",  64'(sc0),  pack_scores(0, 2, 4));
      chk("i0_winner", 64'(wid0), 64'(mw[0]));
      chk("i0_over",   64'(go0),  64'(mo[0]));
      chk("i0_led",    64'(led0), 64'(ml[0]));
      chk("i1_score",  64'(sc1),  pack_scores(1, 4, 3));
      chk("i1_winner", 64'(wid1), 64'(mw[1]));
      chk("i1_over",   64'(go1),  64'(mo[1]));
      chk("i1_led",    64'(led1), 64'(ml[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse0(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      wp0 = v;
      tick();
    end
    wp0 = '0;
  endtask

  initial begin
    r0 = 1'b1; r1 = 1'b1; nm0 = 1'b0; nm1 = 1'b0; wp0 = '0; wp1 = '0;
    tick(); tick();
    r0 = 1'b0; r1 = 1'b0;
    run = 1'b1;
    chk("reset_score", 64'(sc0), 64'h0);
    chk("reset_led", 64'(led0), 64'h0);
    chk("reset_over", 64'(go0), 64'h0);

    // Three round wins for player 0.
    pulse0(2'b01, 3);
    chk("p0_three_score", 64'(sc0), 64'h03);
    tick();
    chk("p0_three_led", 64'(led0), 64'h0007);
    chk("p0_three_over", 64'(go0), 64'h0);

    // Tie is discarded.
    pulse0(2'b11, 1);
    chk("tie_score", 64'(sc0), 64'h03);
    tick();
    chk("tie_led", 64'(led0), 64'h0007);

    // Player 1 takes the match.
    pulse0(2'b10, 8);
    chk("p1_win_over", 64'(go0), 64'h1);
    chk("p1_win_id", 64'(wid0), 64'h1);
    chk("p1_win_score", 64'(sc0), 64'h83);
    chk("p1_win_led_pre", 64'(led0), 64'h7F07);
    tick();
    chk("blink_dark", 64'(led0), 64'h0007);
    for (int i = 0; i < BD; i++) tick();
    chk("blink_lit", 64'(led0), 64'hFF07);
    for (int i = 0; i < BD; i++) tick();
    chk("blink_dark2", 64'(led0), 64'h0007);

    // Pulses in OVER are ignored, then a new match clears everything.
    pulse0(2'b01, 5);
    chk("over_frozen", 64'(sc0), 64'h83);
    nm0 = 1'b1; tick(); nm0 = 1'b0;
    chk("nm_over", 64'(go0), 64'h0);
    chk("nm_score", 64'(sc0), 64'h0);
    chk("nm_led", 64'(led0), 64'h0);
    chk("nm_winner", 64'(wid0), 64'h0);

    // Reset mid-blink.
    pulse0(2'b01, 8);
    for (int i = 0; i < 6; i++) tick();
    r0 = 1'b1; tick(); r0 = 1'b0;
    chk("rst_over_score", 64'(sc0), 64'h0);
    chk("rst_over_led", 64'(led0), 64'h0);
    chk("rst_over_go", 64'(go0), 64'h0);
    pulse0(2'b01, 1);
    chk("rst_then_pulse", 64'(sc0), 64'h01);

    // Four-player instance: player 2 reaches 6 wins, field saturates before blinking.
    for (int i = 0; i < 6; i++) begin
      wp1 = 4'b0100;
      tick();
    end
    wp1 = '0;
    chk("np4_led_sat", 64'(led1[11:8]), 64'hF);
    chk("np4_winner", 64'(wid1), 64'h2);
    chk("np4_over", 64'(go1), 64'h1);
    chk("np4_score", 64'(sc1), 64'h180);
    tick();
    chk("np4_blink_dark", 64'(led1[11:8]), 64'h0);
    nm1 = 1'b1; tick(); nm1 = 1'b0;

    // Randomized traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      r0  = ($urandom_range(0, 299) == 0);
      r1  = ($urandom_range(0, 299) == 0);
      nm0 = ($urandom_range(0, 59) == 0);
      nm1 = ($urandom_range(0, 59) == 0);
      wp0 = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      wp1 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 5) == 0) wp1 = 4'b0001 << $urandom_range(0, 3);
      tick();
    end
    r0 = 1'b0; r1 = 1'b0; nm0 = 1'b0; nm1 = 1'b0; wp0 = '0; wp1 = '0;
    tick(); tick();
    @(negedge clk);
    #1;
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
